// File: rtl/ptcalc_mul_pipe.sv
// ptcalc_mul_pipe
//   Pipelined fixed-point multiplier for the ptcalc datapath. Each operand can
//   be signed or unsigned. The full-width product is rounded (half-up),
//   arithmetically shifted right, and then saturated or wrapped to DOUT_W bits.
//   A sideband tag travels with every sample. One global stall signal freezes
//   every stage while a valid output is waiting for the downstream consumer.
//
//   Stage layout (NUM_STAGE >= 2):
//     stage 0                : registered, extended operands
//     stages 1..NUM_STAGE-2  : registered full-width product (delay line)
//     stage NUM_STAGE-1      : registered rounded/shifted/saturated result
//   With NUM_STAGE == 1, the multiply and the post-processing both feed the
//   single output register combinationally.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   synchronous active-low reset
//   in_valid   in   input sample valid
//   in_ready   out  block accepts a sample this cycle
//   din0       in   operand 0 (DIN0_W bits)
//   din1       in   operand 1 (DIN1_W bits)
//   in_tag     in   sideband tag of the input sample
//   out_valid  out  dout / out_tag / ovf hold a valid result
//   out_ready  in   downstream accepts the output
//   dout       out  post-processed product (DOUT_W bits)
//   out_tag    out  tag of the sample on dout
//   ovf        out  result fell outside the DOUT_W range
module ptcalc_mul_pipe #(
    parameter int DIN0_W      = 16,
    parameter int DIN1_W      = 28,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int DOUT_W      = 44,
    parameter int SHIFT       = 0,
    parameter int ROUND       = 0,
    parameter int SAT         = 0,
    parameter int NUM_STAGE   = 3,
    parameter int TAG_W       = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN0_W-1:0] din0,
    input  logic [DIN1_W-1:0] din1,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] dout,
    output logic [TAG_W-1:0]  out_tag,
    output logic              ovf
);

    // One extra bit lets an unsigned operand be zero-extended into a signed
    // value. Every product of the extended operands fits in PW bits.
    localparam int PW = DIN0_W + DIN1_W + 1;
    // One more bit keeps the rounding addition free of overflow.
    localparam int RW = PW + 1;
    localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    localparam logic signed [RW-1:0] ONE  = 1;
    localparam logic signed [RW-1:0] RND  = (ROUND != 0 && SHIFT > 0) ?
                                            (ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [RW-1:0] OMAX = RES_SIGNED ? (ONE <<< (DOUT_W - 1)) - ONE
                                                       : (ONE <<< DOUT_W) - ONE;
    localparam logic signed [RW-1:0] OMIN = RES_SIGNED ? -(ONE <<< (DOUT_W - 1)) : '0;

    generate
        if (NUM_STAGE < 1 || DOUT_W < 1 || DOUT_W > DIN0_W + DIN1_W ||
            SHIFT < 0 || SHIFT > DIN0_W + DIN1_W - 1) begin : g_param_check
            $error("ptcalc_mul_pipe: illegal parameter combination");
        end
    endgenerate

    function automatic logic signed [PW-1:0] ext0(input logic [DIN0_W-1:0] d);
        return {{(PW - DIN0_W){(DIN0_SIGNED != 0) && d[DIN0_W-1]}}, d};
    endfunction

    function automatic logic signed [PW-1:0] ext1(input logic [DIN1_W-1:0] d);
        return {{(PW - DIN1_W){(DIN1_SIGNED != 0) && d[DIN1_W-1]}}, d};
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic signed [PW-1:0] a,
                                                 input logic signed [PW-1:0] b);
        return a * b;
    endfunction

    // Returns {ovf, dout} for a full-width product.
    function automatic logic [DOUT_W:0] post_proc(input logic signed [PW-1:0] p);
        logic signed [RW-1:0] sum;
        logic signed [RW-1:0] r;
        logic                 hi;
        logic                 lo;
        logic [DOUT_W-1:0]    res;
        sum = RW'(p) + RND;
        r   = sum >>> SHIFT;
        hi  = r > OMAX;
        lo  = r < OMIN;
        if (SAT != 0 && hi) begin
            res = OMAX[DOUT_W-1:0];
        end else if (SAT != 0 && lo) begin
            res = OMIN[DOUT_W-1:0];
        end else begin
            res = r[DOUT_W-1:0];
        end
        return {hi || lo, res};
    endfunction

    logic [NUM_STAGE-1:0] vld_reg;
    logic [TAG_W-1:0]     tag_reg [NUM_STAGE];
    logic [DOUT_W-1:0]    dout_reg;
    logic                 ovf_reg;
    logic                 advance;
    logic                 accept;

    // A single global stall keeps the stage spacing fixed. Bubbles are never
    // compressed, so every stage uses the same enable.
    assign out_valid = vld_reg[NUM_STAGE-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && ap_rst_n;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            vld_reg <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                tag_reg[i] <= '0;
            end
        end else if (advance) begin
            vld_reg[0] <= accept;
            if (accept) begin
                tag_reg[0] <= in_tag;
            end
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_reg[i] <= vld_reg[i-1];
                if (vld_reg[i-1]) begin
                    tag_reg[i] <= tag_reg[i-1];
                end
            end
        end
    end

    generate
        if (NUM_STAGE == 1) begin : g_one
            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    dout_reg <= '0;
                    ovf_reg  <= 1'b0;
                end else if (accept) begin
                    {ovf_reg, dout_reg} <= post_proc(mul(ext0(din0), ext1(din1)));
                end
            end
        end else begin : g_multi
            logic signed [PW-1:0] op0_reg;
            logic signed [PW-1:0] op1_reg;
            // prod_chain[k] is the product that leaves stage k-1.
            logic signed [PW-1:0] prod_chain [1:NUM_STAGE-1];

            always_ff @(posedge ap_clk) begin
                if (accept) begin
                    op0_reg <= ext0(din0);
                    op1_reg <= ext1(din1);
                end
            end

            for (genvar gi = 1; gi < NUM_STAGE; gi++) begin : g_prod
                if (gi == 1) begin : g_mul
                    assign prod_chain[gi] = mul(op0_reg, op1_reg);
                end else begin : g_dly
                    logic signed [PW-1:0] p_reg;
                    always_ff @(posedge ap_clk) begin
                        if (advance && vld_reg[gi-2]) begin
                            p_reg <= prod_chain[gi-1];
                        end
                    end
                    assign prod_chain[gi] = p_reg;
                end
            end

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    dout_reg <= '0;
                    ovf_reg  <= 1'b0;
                end else if (advance && vld_reg[NUM_STAGE-2]) begin
                    {ovf_reg, dout_reg} <= post_proc(prod_chain[NUM_STAGE-1]);
                end
            end
        end
    endgenerate

    assign dout    = dout_reg;
    assign ovf     = ovf_reg;
    assign out_tag = tag_reg[NUM_STAGE-1];

endmodule
